pwm_speed_sequencer: RTL and testbench

//   Sequences the 3-bit speed code and enable of the PWM generator (ancho). It accepts

---
 rtl/pwm_speed_sequencer.sv | 122 ++++++++++++
 tb/tb_pwm_speed_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_speed_sequencer.sv
// pwm_speed_sequencer: ramps the PWM speed code toward commanded targets.
// Ports: clock/reset, cmd_* valid/ready command, pwm_enable/pwm_speed out,
// busy while ramping, at_target pulse when a command completes.
module pwm_speed_sequencer #(
  parameter int SPEED_W = 3,
  parameter int DWELL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SPEED_W-1:0] cmd_target,
  input  logic               cmd_stop,
  input  logic [DWELL_W-1:0] cmd_dwell,
  output logic               pwm_enable,
  output logic [SPEED_W-1:0] pwm_speed,
  output logic               busy,
  output logic               at_target
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN,
    HOLD
  } state_t;

  state_t             state;
  logic [SPEED_W-1:0] tgt;
  logic               stop_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;

  logic               accept;
  logic [SPEED_W-1:0] new_tgt;
  logic [DWELL_W-1:0] new_dwell;
  logic [SPEED_W-1:0] next_speed;

  always_comb begin
    accept    = cmd_valid & cmd_ready;
    new_tgt   = cmd_stop ? '0 : cmd_target;
    new_dwell = (cmd_dwell == '0)
              ? DWELL_W'(1) : cmd_dwell;
    // Only used while ramping, where the
    // target bounds the step: no wrap.
    next_speed = (state == RAMP_UP)
               ? pwm_speed + SPEED_W'(1)
               : pwm_speed - SPEED_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tgt        <= '0;
      stop_q     <= 1'b0;
      dwell_q    <= '0;
      cnt        <= '0;
      pwm_speed  <= '0;
      pwm_enable <= 1'b0;
      busy       <= 1'b0;
      at_target  <= 1'b0;
      cmd_ready  <= 1'b1;
    end else begin
      at_target <= 1'b0;
      unique case (state)
        IDLE, HOLD: begin
          if (accept) begin
            tgt     <= new_tgt;
            stop_q  <= cmd_stop;
            dwell_q <= new_dwell;
            cnt     <= new_dwell - DWELL_W'(1);
            if (!cmd_stop)
              pwm_enable <= 1'b1;
            unique case (1'b1)
              (new_tgt > pwm_speed): begin
                state     <= RAMP_UP;
                busy      <= 1'b1;
                cmd_ready <= 1'b0;
              end
              (new_tgt < pwm_speed): begin
                state     <= RAMP_DOWN;
                busy      <= 1'b1;
                cmd_ready <= 1'b0;
              end
              default: begin
                at_target <= 1'b1;
                if (cmd_stop) begin
                  state      <= IDLE;
                  pwm_enable <= 1'b0;
                end else begin
                  state <= HOLD;
                end
              end
            endcase
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (cnt == '0) begin
            pwm_speed <= next_speed;
            cnt       <= dwell_q - DWELL_W'(1);
            // Completion is flagged with the
            // final step, not a cycle later.
            if (next_speed == tgt) begin
              at_target <= 1'b1;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              if (stop_q) begin
                state      <= IDLE;
                pwm_enable <= 1'b0;
              end else begin
                state <= HOLD;
              end
            end
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_speed_sequencer.sv
// tb_pwm_speed_sequencer: directed and random commands vs. a
// closed-form trajectory model of the speed ramp.
module tb_pwm_speed_sequencer;

  localparam int SW = 3;
  localparam int DW = 16;

  logic          clock;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [SW-1:0] cmd_target;
  logic          cmd_stop;
  logic [DW-1:0] cmd_dwell;
  logic          pwm_enable;
  logic [SW-1:0] pwm_speed;
  logic          busy;
  logic          at_target;

  pwm_speed_sequencer #(
    .SPEED_W(SW),
    .DWELL_W(DW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_target(cmd_target),
    .cmd_stop  (cmd_stop),
    .cmd_dwell (cmd_dwell),
    .pwm_enable(pwm_enable),
    .pwm_speed (pwm_speed),
    .busy      (busy),
    .at_target (at_target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // model: a command is a straight line from
  // start to tgt, one code per d cycles
  int m_speed, m_en, m_ramp, m_ready, m_pulse;
  int c_start, c_tgt, c_d, c_stop, c_len, c_k;
  int t_edge;

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0d exp=%0d",
               tag, t_edge, got, exp);
    end
  endtask

  task automatic model_edge();
    int e, n, dir;
    m_pulse = 0;
    if (reset) begin
      m_speed = 0; m_en = 0; m_ramp = 0;
      m_ready = 1;
    end else if (m_ready && cmd_valid) begin
      c_k     = t_edge;
      c_start = m_speed;
      c_stop  = cmd_stop;
      c_tgt   = cmd_stop ? 0 : int'(cmd_target);
      c_d     = (cmd_dwell == 0) ? 1
              : int'(cmd_dwell);
      c_len   = (c_tgt > c_start)
              ? c_tgt - c_start
              : c_start - c_tgt;
      if (!cmd_stop) m_en = 1;
      if (c_len == 0) begin
        m_pulse = 1;
        if (c_stop) m_en = 0;
      end else begin
        m_ramp  = 1;
        m_ready = 0;
      end
    end else if (m_ramp) begin
      e   = t_edge - c_k;
      n   = e / c_d;
      if (n > c_len) n = c_len;
      dir = (c_tgt > c_start) ? 1 : -1;
      m_speed = c_start + dir * n;
      if (e == c_len * c_d) begin
        m_pulse = 1;
        m_ramp  = 0;
        m_ready = 1;
        if (c_stop) m_en = 0;
      end
    end
  endtask

  task automatic cyc(
    input logic          v,
    input logic [SW-1:0] tg,
    input logic          st,
    input logic [DW-1:0] dw,
    input logic          rs
  );
    @(negedge clock);
    cmd_valid  = v;
    cmd_target = tg;
    cmd_stop   = st;
    cmd_dwell  = dw;
    reset      = rs;
    @(posedge clock);
    t_edge++;
    model_edge();
    #1;
    check("speed", int'(pwm_speed), m_speed);
    check("enable", int'(pwm_enable), m_en);
    check("busy", int'(busy), m_ramp);
    check("ready", int'(cmd_ready), m_ready);
    check("at_target", int'(at_target), m_pulse);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    t_edge = 0;
    m_speed = 0; m_en = 0; m_ramp = 0;
    m_ready = 1; m_pulse = 0;
    cmd_valid = 0; cmd_target = 0;
    cmd_stop = 0; cmd_dwell = 0;
    reset = 1;

    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    idle(1);
    check("rst_speed", int'(pwm_speed), 0);
    check("rst_ready", int'(cmd_ready), 1);

    // ramp 0->5 dwell 3 while a second
    // command waits, then ramps down to 1
    cyc(1'b1, 3'd5, 1'b0, 16'd3, 1'b0);
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 3'd1, 1'b0, 16'd3, 1'b0);
    idle(14);
    check("hold_at_1", int'(pwm_speed), 1);

    // up to 5 fast, then 5->2 with dwell 0
    cyc(1'b1, 3'd5, 1'b0, 16'd1, 1'b0);
    idle(6);
    cyc(1'b1, 3'd2, 1'b0, 16'd0, 1'b0);
    idle(4);
    check("hold_at_2", int'(pwm_speed), 2);

    // stop from 2 with dwell 2, then a
    // stop issued while already idle
    cyc(1'b1, 3'd6, 1'b1, 16'd2, 1'b0);
    idle(6);
    check("stopped", int'(pwm_enable), 0);
    cyc(1'b1, 3'd4, 1'b1, 16'd5, 1'b0);
    idle(2);

    // hold at same speed, and target 0
    cyc(1'b1, 3'd0, 1'b0, 16'd2, 1'b0);
    idle(2);

    // reset mid-ramp at speed 3
    cyc(1'b1, 3'd7, 1'b0, 16'd2, 1'b0);
    idle(6);
    check("pre_rst", int'(pwm_speed), 3);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    idle(3);

    // full-scale ramp to 7 and back
    cyc(1'b1, 3'd7, 1'b0, 16'd1, 1'b0);
    idle(9);
    cyc(1'b1, 3'd0, 1'b1, 16'd1, 1'b0);
    idle(9);

    for (int i = 0; i < 4000; i++) begin
      logic          v, st, rs;
      logic [SW-1:0] tg;
      logic [DW-1:0] dw;
      v  = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) == 0);
      tg = SW'($urandom);
      dw = ($urandom_range(0, 9) == 0)
         ? DW'($urandom_range(0, 20))
         : DW'($urandom_range(0, 4));
      rs = ($urandom_range(0, 299) == 0);
      cyc(v, tg, st, dw, rs);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
